cpu1_oci_dct_ctrl: RTL and testbench
====================================

CPU1_OCI_DCT_CTRL -- requirements
Module: cpu1_oci_dct_ctrl

Interface
Parameters:
REQ-001 SHALL provide parameter IDLE_TIMEOUT, default 255, meaning idle cycles before auto-flush of a partial buffer (0 = auto-flush disabled, range 0..255).

Ports:
REQ-002 SHALL provide: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide: trc_on  input  1  trace capture enable.
REQ-005 SHALL provide: atom_valid  input  1  trace atom offered.
REQ-006 SHALL provide: atom_data  input  2  trace atom payload.
REQ-007 SHALL provide: atom_ready  output  1  atom accepted this cycle when high with atom_valid.
REQ-008 SHALL provide: flush  input  1  single-cycle request to emit the partial buffer.
REQ-009 SHALL provide: dct_buffer  output  30  packing accumulator, 15 two-bit slots.
REQ-010 SHALL provide: dct_count  output  4  occupied slots in dct_buffer, 0..15.
REQ-011 SHALL provide: word_valid  output  1  packed word available.
REQ-012 SHALL provide: word_data  output  30  packed word.
REQ-013 SHALL provide: word_count  output  4  valid slots in word_data, 1..15.
REQ-014 SHALL provide: word_ready  input  1  consumer takes the word when high with word_valid.
REQ-015 SHALL provide: overflow  output  1  sticky flag, atom dropped.
REQ-016 SHALL provide: overflow_clr  input  1  clears overflow.

Function
REQ-017 SHALL drive atom_ready = trc_on AND dct_count < 15; atoms offered while atom_ready is low SHALL be dropped, with no producer stall.
REQ-018 SHALL, on accept, shift atom_data in at the LSBs: dct_buffer <= {dct_buffer[27:0], atom_data}; dct_count increments by 1.
REQ-019 SHALL have a one-entry output slot; the slot is free when word_valid is 0 or word_ready is 1 in the same cycle.
REQ-020 SHALL transfer to the output slot when the slot is free and one of the following holds: dct_count==15; flush_pend and dct_count>0; idle timeout expired.
REQ-021 SHALL, on transfer: word_data <= dct_buffer; word_count <= dct_count; word_valid <= 1; dct_buffer <= 0; dct_count <= 0.
REQ-022 SHALL, on transfer coincident with an accept (partial flush/timeout only), restart the accumulator with the new atom: dct_count=1, dct_buffer={28'b0, atom_data}.
REQ-023 SHALL hold word_valid, word_data and word_count stable until word_ready; word_valid falls the cycle after word_ready with no new transfer.
REQ-024 SHALL implement FSM states IDLE (count 0, no pending), FILL (count>0), DRAIN (transfer required but slot busy); DRAIN returns to IDLE or FILL on transfer.
REQ-025 SHALL set flush_pend on a flush pulse or on a trc_on 1->0 edge; flush_pend clears on transfer or when dct_count==0.
REQ-026 SHALL run an 8-bit idle counter: clear on accept or when dct_count==0, otherwise increment, saturating; at count==IDLE_TIMEOUT (nonzero) the timeout condition is raised.
REQ-027 SHALL set overflow when atom_valid AND trc_on AND NOT atom_ready; set wins over a simultaneous overflow_clr.
REQ-028 SHALL accept no atoms when trc_on is 0, and SHALL NOT set overflow then.

Reset
REQ-029 SHALL, on reset_n low, asynchronously clear dct_buffer=0, dct_count=0, word_valid=0, word_data=0, word_count=0, overflow=0, flush_pend=0, idle counter=0, FSM=IDLE.
REQ-030 SHALL drive atom_ready per REQ-017 during reset; since dct_count=0 there, atom_ready=trc_on.
REQ-031 SHALL discard a partial buffer and any pending word when reset occurs mid-operation.

Verification
REQ-032 SHALL cover: 15 atoms 2'b01, word_ready=1 -> word_valid one cycle after the 15th accept, word_data=30'h15555555, word_count=15, dct_count=0.
REQ-033 SHALL cover: 3 atoms 3,2,1 then flush -> word_data=30'h39, word_count=3.
REQ-034 SHALL cover: word_ready=0, 15 atoms emitted, then 15 more atoms -> second 15 held in DRAIN, atom_ready=0, 16th extra atom sets overflow; word_ready=1 -> second word transfers the next cycle.
REQ-035 SHALL cover: IDLE_TIMEOUT=4, 2 atoms then idle -> transfer after 4 idle cycles, word_count=2.
REQ-036 SHALL cover: flush coincident with accept at dct_count=5 -> word_count=5 and dct_count=1; reset_n low mid-fill -> all outputs 0 at the next sample.

Source files
------------

// File: rtl/cpu1_oci_dct_ctrl.sv
//==============================================================================
// cpu1_oci_dct_ctrl : packs 2-bit trace atoms into 15-slot words, hands them
// to a one-entry output slot on full, flush, trace-off or idle timeout.
// Revision: 1.0
//==============================================================================
`default_nettype none

module cpu1_oci_dct_ctrl #(
  parameter int unsigned IDLE_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trc_on,
  input  logic        atom_valid,
  input  logic [1:0]  atom_data,
  output logic        atom_ready,
  input  logic        flush,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        word_valid,
  output logic [29:0] word_data,
  output logic [3:0]  word_count,
  input  logic        word_ready,
  output logic        overflow,
  input  logic        overflow_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [3:0] C_FULL    = 4'd15;
  localparam logic [7:0] C_TIMEOUT = 8'(IDLE_TIMEOUT);

  state_e      state_q, state_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wvalid_q, wvalid_d;
  logic [29:0] wdata_q, wdata_d;
  logic [3:0]  wcount_q, wcount_d;
  logic        ovf_q, ovf_d;
  logic        fpend_q, fpend_d;
  logic [7:0]  idle_q, idle_d;
  logic        trc_q;

  logic w_accept;
  logic w_slot_free;
  logic w_flush_req;
  logic w_timeout;
  logic w_need;
  logic w_xfer;

  assign atom_ready = trc_on & (cnt_q != C_FULL);

  always_comb begin
    w_accept    = atom_valid & atom_ready;
    w_slot_free = ~wvalid_q | word_ready;
    // A flush pulse or trace-off edge acts in the same cycle it arrives,
    // so a flush coincident with an accept emits the pre-accept contents.
    w_flush_req = fpend_q | flush | (trc_q & ~trc_on);
    w_timeout   = (C_TIMEOUT != 8'd0) && (idle_q >= C_TIMEOUT);
    // DRAIN remembers that a transfer was owed even if its trigger goes away.
    w_need      = (cnt_q != 4'd0) &&
                  ((cnt_q == C_FULL) || w_flush_req || w_timeout ||
                   (state_q == ST_DRAIN));
    w_xfer      = w_need & w_slot_free;
  end

  always_comb begin
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    wvalid_d = wvalid_q;
    wdata_d  = wdata_q;
    wcount_d = wcount_q;
    state_d  = state_q;

    if (w_xfer) begin
      wdata_d  = buf_q;
      wcount_d = cnt_q;
      wvalid_d = 1'b1;
      if (w_accept) begin
        buf_d = {28'b0, atom_data};
        cnt_d = 4'd1;
      end else begin
        buf_d = 30'b0;
        cnt_d = 4'd0;
      end
    end else begin
      if (word_ready) begin
        wvalid_d = 1'b0;
      end
      if (w_accept) begin
        buf_d = {buf_q[27:0], atom_data};
        cnt_d = cnt_q + 4'd1;
      end
    end

    if (w_need && !w_slot_free) begin
      state_d = ST_DRAIN;
    end else if (cnt_d != 4'd0) begin
      state_d = ST_FILL;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    fpend_d = (fpend_q | flush | (trc_q & ~trc_on)) & ~w_xfer & (cnt_q != 4'd0);

    if (w_accept || w_xfer || (cnt_q == 4'd0)) begin
      idle_d = 8'd0;
    end else if (idle_q != 8'hFF) begin
      idle_d = idle_q + 8'd1;
    end else begin
      idle_d = idle_q;
    end

    // A new drop wins over a simultaneous clear.
    ovf_d = (atom_valid & trc_on & ~atom_ready) | (ovf_q & ~overflow_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      buf_q    <= 30'b0;
      cnt_q    <= 4'd0;
      wvalid_q <= 1'b0;
      wdata_q  <= 30'b0;
      wcount_q <= 4'd0;
      ovf_q    <= 1'b0;
      fpend_q  <= 1'b0;
      idle_q   <= 8'd0;
      trc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      wvalid_q <= wvalid_d;
      wdata_q  <= wdata_d;
      wcount_q <= wcount_d;
      ovf_q    <= ovf_d;
      fpend_q  <= fpend_d;
      idle_q   <= idle_d;
      trc_q    <= trc_on;
    end
  end

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign word_valid = wvalid_q;
  assign word_data  = wdata_q;
  assign word_count = wcount_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu1_oci_dct_ctrl.sv
//==============================================================================
// tb_cpu1_oci_dct_ctrl : directed self-checking bench for the atom packer.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_cpu1_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trc_on;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        flush;
  logic        word_ready;
  logic        overflow_clr;

  logic        atom_ready,   atom_ready_t;
  logic [29:0] dct_buffer,   dct_buffer_t;
  logic [3:0]  dct_count,    dct_count_t;
  logic        word_valid,   word_valid_t;
  logic [29:0] word_data,    word_data_t;
  logic [3:0]  word_count,   word_count_t;
  logic        overflow,     overflow_t;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu1_oci_dct_ctrl dut (
    .clk(clk), .reset_n(reset_n), .trc_on(trc_on),
    .atom_valid(atom_valid), .atom_data(atom_data), .atom_ready(atom_ready),
    .flush(flush), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .word_valid(word_valid), .word_data(word_data), .word_count(word_count),
    .word_ready(word_ready), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  cpu1_oci_dct_ctrl #(.IDLE_TIMEOUT(4)) dut_t (
    .clk(clk), .reset_n(reset_n), .trc_on(trc_on),
    .atom_valid(atom_valid), .atom_data(atom_data), .atom_ready(atom_ready_t),
    .flush(flush), .dct_buffer(dct_buffer_t), .dct_count(dct_count_t),
    .word_valid(word_valid_t), .word_data(word_data_t), .word_count(word_count_t),
    .word_ready(word_ready), .overflow(overflow_t), .overflow_clr(overflow_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #1;
    reset_n      = 1'b0;
    trc_on       = 1'b1;
    atom_valid   = 1'b0;
    atom_data    = 2'd0;
    flush        = 1'b0;
    word_ready   = rdy;
    overflow_clr = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic [1:0] d);
    atom_valid = 1'b1;
    atom_data  = d;
    tick();
    atom_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, including atom_ready tracking trc_on while in reset.
    reset_n = 1'b0; trc_on = 1'b1; atom_valid = 1'b0; atom_data = 2'd0;
    flush = 1'b0; word_ready = 1'b1; overflow_clr = 1'b0;
    #2;
    check("rst_count",  32'(dct_count),  32'd0);
    check("rst_wvalid", 32'(word_valid), 32'd0);
    check("rst_ready",  32'(atom_ready), 32'd1);
    check("rst_ovf",    32'(overflow),   32'd0);

    // 15 atoms of 01 with consumer always ready.
    do_reset(1'b1);
    for (int i = 0; i < 15; i++) send(2'b01);
    check("full_cnt",    32'(dct_count),  32'd15);
    check("full_rdy",    32'(atom_ready), 32'd0);
    check("full_wv_pre", 32'(word_valid), 32'd0);
    tick();
    check("full_wv",     32'(word_valid), 32'd1);
    check("full_wdata",  32'(word_data),  32'h15555555);
    check("full_wcnt",   32'(word_count), 32'd15);
    check("full_dcnt",   32'(dct_count),  32'd0);
    tick();
    check("full_wv_drop", 32'(word_valid), 32'd0);

    // 3 atoms then flush.
    do_reset(1'b1);
    send(2'd3); send(2'd2); send(2'd1);
    check("fl_buf", 32'(dct_buffer), 32'h39);
    flush = 1'b1; tick(); flush = 1'b0;
    check("fl_wv",    32'(word_valid), 32'd1);
    check("fl_wdata", 32'(word_data),  32'h39);
    check("fl_wcnt",  32'(word_count), 32'd3);
    check("fl_dcnt",  32'(dct_count),  32'd0);

    // Consumer stalled: second full word waits in DRAIN, extra atom overflows.
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) send(2'b10);
    tick();
    check("bp_w1_valid", 32'(word_valid), 32'd1);
    check("bp_w1_data",  32'(word_data),  32'h2AAAAAAA);
    for (int i = 0; i < 15; i++) send(2'b11);
    check("bp_cnt",     32'(dct_count),  32'd15);
    check("bp_rdy",     32'(atom_ready), 32'd0);
    check("bp_ovf0",    32'(overflow),   32'd0);
    send(2'b01);
    check("bp_ovf1",    32'(overflow),   32'd1);
    check("bp_cnt_hold",32'(dct_count),  32'd15);
    tick(); tick();
    check("bp_hold_data", 32'(word_data), 32'h2AAAAAAA);
    word_ready = 1'b1;
    tick();
    check("bp_w2_valid", 32'(word_valid), 32'd1);
    check("bp_w2_data",  32'(word_data),  32'h3FFFFFFF);
    check("bp_w2_cnt",   32'(word_count), 32'd15);
    check("bp_dcnt",     32'(dct_count),  32'd0);
    check("bp_ovf_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    check("bp_ovf_clr",  32'(overflow),   32'd0);

    // Idle timeout of 4 on dut_t; the default instance keeps its atoms.
    do_reset(1'b1);
    send(2'd1); send(2'd2);
    for (int i = 0; i < 4; i++) tick();
    check("to_wv_pre", 32'(word_valid_t), 32'd0);
    tick();
    check("to_wv",     32'(word_valid_t), 32'd1);
    check("to_wcnt",   32'(word_count_t), 32'd2);
    check("to_wdata",  32'(word_data_t),  32'h6);
    check("to_dcnt",   32'(dct_count_t),  32'd0);
    check("to_def_cnt", 32'(dct_count),   32'd2);

    // Flush coincident with accept at count 5, then reset mid-fill.
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) send(2'b01);
    atom_valid = 1'b1; atom_data = 2'b10; flush = 1'b1;
    tick();
    atom_valid = 1'b0; flush = 1'b0;
    check("fa_wcnt",  32'(word_count), 32'd5);
    check("fa_wdata", 32'(word_data),  32'h155);
    check("fa_dcnt",  32'(dct_count),  32'd1);
    check("fa_buf",   32'(dct_buffer), 32'h2);
    send(2'b11); send(2'b11);
    reset_n = 1'b0;
    #1;
    check("mr_buf",    32'(dct_buffer), 32'd0);
    check("mr_cnt",    32'(dct_count),  32'd0);
    check("mr_wv",     32'(word_valid), 32'd0);
    check("mr_wdata",  32'(word_data),  32'd0);
    check("mr_wcnt",   32'(word_count), 32'd0);
    check("mr_ovf",    32'(overflow),   32'd0);

    // Trace-off edge flushes; atoms with trace off are neither taken nor overflow.
    do_reset(1'b1);
    send(2'd3); send(2'd3);
    trc_on = 1'b0;
    tick();
    check("to_off_wv",   32'(word_valid), 32'd1);
    check("to_off_wcnt", 32'(word_count), 32'd2);
    check("to_off_data", 32'(word_data),  32'hF);
    atom_valid = 1'b1; atom_data = 2'd1;
    #1;
    check("off_rdy", 32'(atom_ready), 32'd0);
    tick();
    atom_valid = 1'b0;
    check("off_ovf", 32'(overflow),  32'd0);
    check("off_cnt", 32'(dct_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
